// File: rtl/ibex_insn_encoder.sv
// RV32I field-level instruction encoder with an output FIFO, feeding the decoder harness.
// Illegal requests are stored as an all-zero word tagged illegal and counted.
module ibex_insn_encoder #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [2:0]       req_class_i,
   input  logic [3:0]       req_op_i,
   input  logic [1:0]       req_size_i,
   input  logic             req_unsigned_i,
   input  logic [4:0]       req_rd_i,
   input  logic [4:0]       req_rs1_i,
   input  logic [4:0]       req_rs2_i,
   input  logic [19:0]      req_imm_i,
   output logic             insn_valid_o,
   input  logic             insn_ready_i,
   output logic [31:0]      insn_o,
   output logic             insn_illegal_o,
   output logic [CNT_W-1:0] emit_cnt_o,
   output logic [CNT_W-1:0] illegal_cnt_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OccW = $clog2(DEPTH + 1);
   localparam logic [OccW-1:0] FullCnt = OccW'(DEPTH);

   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic        op_ok;
   logic        is_shift;
   logic        illegal;
   logic [11:0] i_imm;
   logic [31:0] enc_word;

   always_comb begin
      funct3   = 3'b000;
      funct7   = 7'b0000000;
      op_ok    = 1'b1;
      is_shift = 1'b0;
      unique case (req_op_i)
         4'd0: funct3 = 3'b000;
         4'd1: begin funct3 = 3'b000; funct7 = 7'b0100000; end
         4'd2: funct3 = 3'b100;
         4'd3: funct3 = 3'b110;
         4'd4: funct3 = 3'b111;
         4'd5: begin funct3 = 3'b101; funct7 = 7'b0100000; is_shift = 1'b1; end
         4'd6: begin funct3 = 3'b101; is_shift = 1'b1; end
         4'd7: begin funct3 = 3'b001; is_shift = 1'b1; end
         4'd8: funct3 = 3'b010;
         4'd9: funct3 = 3'b011;
         default: op_ok = 1'b0;
      endcase
   end

   // Immediate shifts carry funct7 in imm[11:5] and the shift amount in imm[4:0].
   assign i_imm = is_shift ? {funct7, req_imm_i[4:0]} : req_imm_i[11:0];

   always_comb begin
      illegal  = 1'b0;
      enc_word = 32'h0000_0000;
      unique case (req_class_i)
         3'd0: begin
            illegal  = !op_ok;
            enc_word = {funct7, req_rs2_i, req_rs1_i, funct3, req_rd_i, 7'b0110011};
         end
         3'd1: begin
            illegal  = !op_ok || (req_op_i == 4'd1);
            enc_word = {i_imm, req_rs1_i, funct3, req_rd_i, 7'b0010011};
         end
         3'd2: begin
            illegal  = (req_size_i == 2'd3) || ((req_size_i == 2'd2) && req_unsigned_i);
            enc_word = {req_imm_i[11:0], req_rs1_i, req_unsigned_i, req_size_i, req_rd_i,
                        7'b0000011};
         end
         3'd3: begin
            illegal  = (req_size_i == 2'd3);
            enc_word = {req_imm_i[11:5], req_rs2_i, req_rs1_i, 1'b0, req_size_i,
                        req_imm_i[4:0], 7'b0100011};
         end
         3'd4: enc_word = {req_imm_i, req_rd_i, 7'b0110111};
         default: illegal = 1'b1;
      endcase
      if (illegal) begin
         enc_word = 32'h0000_0000;
      end
   end

   logic [31:0]      mem_q [DEPTH];
   logic [DEPTH-1:0] ill_q;
   logic [PtrW-1:0]  wptr_q, rptr_q;
   logic [OccW-1:0]  count_q;
   logic [CNT_W-1:0] emit_q, ill_cnt_q;
   logic             push, pop;

   assign req_ready_o    = (count_q != FullCnt) && !flush_i;
   assign insn_valid_o   = (count_q != '0);
   assign push           = req_valid_i && req_ready_o;
   assign pop            = insn_valid_o && insn_ready_i && !flush_i;
   assign insn_o         = insn_valid_o ? mem_q[rptr_q] : 32'h0000_0000;
   assign insn_illegal_o = insn_valid_o & ill_q[rptr_q];
   assign emit_cnt_o     = emit_q;
   assign illegal_cnt_o  = ill_cnt_q;

   // Storage needs no reset: stale entries are never visible while count is zero.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wptr_q] <= enc_word;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ill_q     <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         emit_q    <= '0;
         ill_cnt_q <= '0;
      end else begin
         if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
         end else begin
            if (push) begin
               ill_q[wptr_q] <= illegal;
               wptr_q        <= wptr_q + PtrW'(1);
            end
            if (pop) begin
               rptr_q <= rptr_q + PtrW'(1);
            end
            if (push && !pop) begin
               count_q <= count_q + OccW'(1);
            end else if (pop && !push) begin
               count_q <= count_q - OccW'(1);
            end
         end
         if (pop) begin
            emit_q <= emit_q + CNT_W'(1);
         end
         if (push && illegal && !(&ill_cnt_q)) begin
            ill_cnt_q <= ill_cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_ibex_insn_encoder.sv
// Directed self-checking bench for ibex_insn_encoder: encodings, illegal handling, FIFO
// boundaries, flush and asynchronous reset.
module tb_ibex_insn_encoder;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_class;
   logic [3:0]  req_op;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [4:0]  req_rd, req_rs1, req_rs2;
   logic [19:0] req_imm;
   logic        insn_valid;
   logic        insn_ready;
   logic [31:0] insn;
   logic        insn_illegal;
   logic [15:0] emit_cnt;
   logic [15:0] illegal_cnt;

   int checks = 0;
   int errors = 0;
   int exp_emit = 0;
   int exp_ill = 0;

   ibex_insn_encoder #(
      .DEPTH (4),
      .CNT_W (16)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .flush_i        (flush),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_class_i    (req_class),
      .req_op_i       (req_op),
      .req_size_i     (req_size),
      .req_unsigned_i (req_unsigned),
      .req_rd_i       (req_rd),
      .req_rs1_i      (req_rs1),
      .req_rs2_i      (req_rs2),
      .req_imm_i      (req_imm),
      .insn_valid_o   (insn_valid),
      .insn_ready_i   (insn_ready),
      .insn_o         (insn),
      .insn_illegal_o (insn_illegal),
      .emit_cnt_o     (emit_cnt),
      .illegal_cnt_o  (illegal_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] cls, input logic [3:0] op, input logic [1:0] sz,
                        input logic uns, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [19:0] imm);
      req_class    = cls;
      req_op       = op;
      req_size     = sz;
      req_unsigned = uns;
      req_rd       = rd;
      req_rs1      = rs1;
      req_rs2      = rs2;
      req_imm      = imm;
      req_valid    = 1'b1;
   endtask

   function automatic logic [31:0] lui_word(input logic [4:0] rd, input logic [19:0] imm);
      return {imm, rd, 7'b0110111};
   endfunction

   // Push one request into an empty FIFO, check the head one cycle later, then pop it.
   task automatic enc_case(input string tag, input logic [2:0] cls, input logic [3:0] op,
                           input logic [1:0] sz, input logic uns, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [19:0] imm, input logic [31:0] exp_word,
                           input logic exp_illegal);
      drive(cls, op, sz, uns, rd, rs1, rs2, imm);
      step();
      req_valid = 1'b0;
      chk({tag, "_word"}, insn, exp_word);
      chk({tag, "_illegal"}, 32'(insn_illegal), 32'(exp_illegal));
      if (exp_illegal) exp_ill++;
      chk({tag, "_illcnt"}, 32'(illegal_cnt), 32'(exp_ill));
      chk({tag, "_emit_before"}, 32'(emit_cnt), 32'(exp_emit));
      insn_ready = 1'b1;
      step();
      insn_ready = 1'b0;
      exp_emit++;
      chk({tag, "_emit_after"}, 32'(emit_cnt), 32'(exp_emit));
      chk({tag, "_drained"}, 32'(insn_valid), 32'd0);
   endtask

   initial begin
      rst_ni       = 1'b0;
      flush        = 1'b0;
      req_valid    = 1'b0;
      insn_ready   = 1'b0;
      req_class    = '0;
      req_op       = '0;
      req_size     = '0;
      req_unsigned = 1'b0;
      req_rd       = '0;
      req_rs1      = '0;
      req_rs2      = '0;
      req_imm      = '0;
      #1;
      chk("rst_valid", 32'(insn_valid), 32'd0);
      chk("rst_insn", insn, 32'd0);
      chk("rst_illegal", 32'(insn_illegal), 32'd0);
      chk("rst_emit", 32'(emit_cnt), 32'd0);
      chk("rst_illcnt", 32'(illegal_cnt), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      step();
      step();
      rst_ni = 1'b1;
      step();

      // Encodings
      enc_case("r_add", 3'd0, 4'd0, 2'd0, 1'b0, 5'd1, 5'd2, 5'd3, 20'h0, 32'h003100B3, 1'b0);
      enc_case("r_sub", 3'd0, 4'd1, 2'd0, 1'b0, 5'd4, 5'd5, 5'd6, 20'h0, 32'h40628233, 1'b0);
      enc_case("i_sra", 3'd1, 4'd5, 2'd0, 1'b0, 5'd5, 5'd6, 5'd0, 20'h3, 32'h40335293, 1'b0);
      enc_case("i_sll", 3'd1, 4'd7, 2'd0, 1'b0, 5'd1, 5'd1, 5'd0, 20'hFE5, 32'h00509093,
               1'b0);
      enc_case("st_w", 3'd3, 4'd0, 2'd2, 1'b1, 5'd0, 5'd8, 5'd7, 20'hFFC, 32'hFE742E23, 1'b0);
      enc_case("ld_bu", 3'd2, 4'd0, 2'd0, 1'b1, 5'd10, 5'd11, 5'd0, 20'h0, 32'h0005C503,
               1'b0);
      enc_case("ld_h", 3'd2, 4'd0, 2'd1, 1'b0, 5'd2, 5'd3, 5'd0, 20'h800, 32'h80019103, 1'b0);
      enc_case("lui", 3'd4, 4'd9, 2'd0, 1'b0, 5'd1, 5'd0, 5'd0, 20'h12345, 32'h123450B7, 1'b0);

      // Illegal requests
      enc_case("i_sub", 3'd1, 4'd1, 2'd0, 1'b0, 5'd1, 5'd2, 5'd3, 20'h1, 32'h0, 1'b1);
      enc_case("cls7", 3'd7, 4'd0, 2'd0, 1'b0, 5'd1, 5'd2, 5'd3, 20'h1, 32'h0, 1'b1);
      enc_case("r_op12", 3'd0, 4'd12, 2'd0, 1'b0, 5'd1, 5'd2, 5'd3, 20'h0, 32'h0, 1'b1);
      enc_case("ld_wu", 3'd2, 4'd0, 2'd2, 1'b1, 5'd1, 5'd2, 5'd0, 20'h0, 32'h0, 1'b1);
      enc_case("st_sz3", 3'd3, 4'd0, 2'd3, 1'b0, 5'd0, 5'd2, 5'd3, 20'h0, 32'h0, 1'b1);

      // Fill past capacity with no consumer
      for (int i = 0; i < 5; i++) begin
         drive(3'd4, 4'd0, 2'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 20'(i * 16 + 1));
         chk("fill_ready", 32'(req_ready), 32'(i < 4));
         step();
      end
      req_valid = 1'b0;
      chk("full_ready", 32'(req_ready), 32'd0);
      insn_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_order", insn, lui_word(5'(i + 1), 20'(i * 16 + 1)));
         step();
      end
      insn_ready = 1'b0;
      exp_emit += 4;
      chk("drain_empty", 32'(insn_valid), 32'd0);
      chk("drain_emit", 32'(emit_cnt), 32'(exp_emit));

      // Continuous push/pop across several pointer wraps
      insn_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         drive(3'd4, 4'd0, 2'd0, 1'b0, 5'(k + 10), 5'd0, 5'd0, 20'(k * 4096 + 7));
         step();
         chk("stream_head", insn, lui_word(5'(k + 10), 20'(k * 4096 + 7)));
      end
      req_valid = 1'b0;
      step();
      insn_ready = 1'b0;
      exp_emit += 10;
      chk("stream_empty", 32'(insn_valid), 32'd0);
      chk("stream_emit", 32'(emit_cnt), 32'(exp_emit));

      // Flush a full FIFO while the consumer is trying to pop
      for (int i = 0; i < 4; i++) begin
         drive(3'd4, 4'd0, 2'd0, 1'b0, 5'(i), 5'd0, 5'd0, 20'(i + 100));
         step();
      end
      req_valid = 1'b0;
      chk("pre_flush_valid", 32'(insn_valid), 32'd1);
      flush      = 1'b1;
      insn_ready = 1'b1;
      step();
      flush      = 1'b0;
      insn_ready = 1'b0;
      chk("flush_valid", 32'(insn_valid), 32'd0);
      chk("flush_insn", insn, 32'd0);
      chk("flush_emit", 32'(emit_cnt), 32'(exp_emit));
      chk("flush_illcnt", 32'(illegal_cnt), 32'(exp_ill));
      flush = 1'b1;
      #1;
      chk("flush_blocks_ready", 32'(req_ready), 32'd0);
      flush = 1'b0;
      #1;
      chk("post_flush_ready", 32'(req_ready), 32'd1);
      drive(3'd4, 4'd0, 2'd0, 1'b0, 5'd3, 5'd0, 5'd0, 20'hABCDE);
      step();
      req_valid = 1'b0;
      chk("post_flush_head", insn, lui_word(5'd3, 20'hABCDE));

      // Asynchronous reset mid-stream
      drive(3'd1, 4'd8, 2'd0, 1'b0, 5'd1, 5'd1, 5'd0, 20'h5);
      step();
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst_valid", 32'(insn_valid), 32'd0);
      chk("arst_insn", insn, 32'd0);
      chk("arst_illegal", 32'(insn_illegal), 32'd0);
      chk("arst_emit", 32'(emit_cnt), 32'd0);
      chk("arst_illcnt", 32'(illegal_cnt), 32'd0);
      chk("arst_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      step();
      rst_ni = 1'b1;
      step();
      chk("post_rst_valid", 32'(insn_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ibex_insn_encoder.md
# ibex_insn_encoder

Stimulus-side RV32I instruction encoder feeding the `ibex_decoder` verification harness. It accepts field-level instruction requests over a valid/ready handshake and encodes each into a 32-bit instruction word. Results are buffered in a small FIFO and presented to the decoder's `instr_rdata_i` / `instr_rdata_alu_i` path over a second valid/ready handshake. Unencodable requests emit `32'h0000_0000` with an illegal flag and are counted.

## Interface
- `DEPTH`, default 4: output FIFO entries; power of two, ≥2.
- `CNT_W`, default 16: width of the emitted and illegal counters.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `flush_i` in 1: synchronous FIFO clear.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when valid & ready.
- `req_class_i` in 3: 0 R-ALU, 1 I-ALU, 2 LOAD, 3 STORE, 4 LUI, 5–7 illegal.
- `req_op_i` in 4: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SRA, 6 SRL, 7 SLL, 8 SLT, 9 SLTU, 10–15 illegal.
- `req_size_i` in 2: 0 byte, 1 half, 2 word, 3 illegal.
- `req_unsigned_i` in 1: unsigned load (LBU/LHU).
- `req_rd_i`, `req_rs1_i`, `req_rs2_i` in 5 each: register indices.
- `req_imm_i` in 20: bits [11:0] used for I/LOAD/STORE; all 20 bits used for LUI.
- `insn_valid_o` out 1: FIFO non-empty.
- `insn_ready_i` in 1: consumer pops when valid & ready.
- `insn_o` out 32: head instruction word.
- `insn_illegal_o` out 1: head entry was an illegal request.
- `emit_cnt_o` out CNT_W: instructions popped; wraps.
- `illegal_cnt_o` out CNT_W: illegal requests accepted; saturates at all-ones.

## Operation
- Encoding is combinational from request fields. The result is written into the FIFO on acceptance.
- funct3 per op:
  - ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111.
  - funct7 is 0100000 for SUB and SRA; otherwise 0000000.
- R-ALU: `{funct7, rs2, rs1, funct3, rd, 0110011}`.
- I-ALU: `{imm[11:0], rs1, funct3, rd, 0010011}`.
  - Shifts replace imm[11:5] with funct7 and use imm[4:0] as the shift amount.
  - SUB is illegal in this class.
- LOAD: `{imm[11:0], rs1, {unsigned, size}, rd, 0000011}`. Size 3 is illegal. Word + unsigned is illegal.
- STORE: `{imm[11:5], rs2, rs1, {0, size}, imm[4:0], 0100011}`. Size 3 is illegal. `req_unsigned_i` is ignored.
- LUI: `{imm[19:0], rd, 0110111}`. `req_op_i` is ignored.
- R-ALU and I-ALU with op 10–15 are illegal.
- Any illegal request stores word `32'h0000_0000` with `insn_illegal_o` = 1 and increments `illegal_cnt_o`, saturating.
- FIFO:
  - Circular buffer with read/write pointers and occupancy count `0..DEPTH`.
  - `req_ready_o = (count != DEPTH) && !flush_i`.
  - `insn_valid_o = (count != 0)`.
  - `insn_o` and `insn_illegal_o` show the head entry, and read as 0 when empty.
- Simultaneous push and pop: occupancy unchanged and both pointers advance. When full, `req_ready_o` is low, so there is no push even with a concurrent pop.
- Pointer wrap from `DEPTH-1` to 0 is seamless.
- `flush_i`:
  - Next cycle count = 0 and pointers = 0.
  - A pop in the same cycle is discarded and does not increment `emit_cnt_o`.
  - Counters are otherwise preserved.
- `emit_cnt_o` increments on every pop and wraps modulo 2^CNT_W.

## Timing
- Reset (async assert, sync deassert):
  - count, pointers, `emit_cnt_o`, `illegal_cnt_o` = 0.
  - `insn_valid_o` = 0, `insn_o` = 0, `insn_illegal_o` = 0.
  - `req_ready_o` = 1 (unless `flush_i` is high).
- Latency: a request accepted at edge N is visible on `insn_o` after edge N (cycle N+1) when the FIFO was empty. There is no combinational path from `req_*` to `insn_*`.
- `illegal_cnt_o` updates at the accepting edge. `emit_cnt_o` updates at the popping edge.
- Throughput: one request and one pop per cycle sustained.
- Reset mid-operation: all FIFO contents are lost and no partial entries remain.
- Inputs are sampled only when `req_valid_i & req_ready_o`.

## Test plan
- R-ALU ADD, rd=1, rs1=2, rs2=3 → `insn_o` = 0x003100B3 one cycle after accept; `emit_cnt_o` 0→1 on pop.
- I-ALU SRA, rd=5, rs1=6, imm=3 → 0x40335293.
- Two further encodings:
  - STORE word, rs1=8, rs2=7, imm=0xFFC → 0xFE742E23.
  - LOAD byte unsigned, rd=10, rs1=11, imm=0 → 0x0005C503.
- LUI, rd=1, imm=0x12345 → 0x123450B7.
- I-ALU SUB → 0x00000000 with `insn_illegal_o` = 1 and `illegal_cnt_o` = 1. Then class 7 → `illegal_cnt_o` = 2.
- FIFO boundaries:
  - Push DEPTH+1 back-to-back with `insn_ready_i` = 0 → `req_ready_o` drops after 4 accepts.
  - Enable pop → entries emerge in order; 10 pushes through continuous push/pop show correct pointer wrap.
  - `flush_i` with a full FIFO → `insn_valid_o` = 0 next cycle and `emit_cnt_o` unchanged.
  - Assert `rst_ni` low mid-stream → all outputs 0 asynchronously.
